// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
//   Serial line plus byte handshake of the UART receive stage, bundled so the
//   receiver and its consumer share a single port.
//
//   rx        serial line into the receiver, idle high
//   ack       consumer accepts the current byte
//   data      last received byte, stable while valid is high
//   valid     byte available, held until ack
//   overrun   sticky, a byte was overwritten before it was acknowledged
//   frame_err one-cycle pulse, stop bit sampled low
//   busy      receiver is inside a frame (or waiting out a break)
//
//   master : line driver / consumer side (drives rx and ack)
//   slave  : the receiver itself
// ---------------------------------------------------------------------------
interface uart_receiver_if;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    output ack,
    input  data,
    input  valid,
    input  overrun,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    input  ack,
    output data,
    output valid,
    output overrun,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receive stage, LSB first, 16x oversampled. Each bit is decided by
//   a majority vote of the synchronised line at ticks 7, 8 and 9 of the bit.
//   Received bytes are offered on a valid/ack handshake; framing errors and
//   overruns are flagged.
//
//   Ports
//     clk  system clock, all logic on the rising edge
//     rst  asynchronous active-high reset
//     bus  uart_receiver_if.slave: rx, ack in; data, valid, overrun,
//          frame_err, busy out
//
//   Parameters
//     CLK_FREQ    system clock in Hz
//     BAUD        line rate in bit/s
//     OVERSAMPLE  ticks per bit, must stay 16 (tick numbering assumes it)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | line idle, looking for a low sample on a tick
//   START  | inside the start bit, rejecting glitches at t=9
//   DATA   | shifting in the 8 data bits, LSB first
//   STOP   | checking the stop bit at t=9, then deliver or flag
//   BREAK  | stop bit was low, waiting for the line to return high
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_receiver_if.slave bus
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_receiver: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
  end

  if (OVERSAMPLE != 16) begin : g_bad_oversample
    $error("uart_receiver: OVERSAMPLE must be 16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Two-flop synchroniser; both flops reset to the idle line level.
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // Free-running oversample tick, independent of the FSM so the tick phase
  // never depends on when a frame starts.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // FSM state and bit-timing registers.
  state_t     state_q;
  state_t     state_nxt;
  logic [3:0] t_q;
  logic [3:0] t_nxt;
  logic [2:0] idx_q;
  logic [2:0] idx_nxt;
  logic [7:0] shift_q;
  logic [7:0] shift_nxt;
  logic       load_byte;
  logic       ferr_set;

  // Samples taken at t=7 and t=8; the vote completes with the live sample
  // at t=9.
  logic s7_q;
  logic s8_q;
  logic maj;

  assign maj = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
    end else if (tick) begin
      if (t_q == 4'd7) begin
        s7_q <= rxs;
      end
      if (t_q == 4'd8) begin
        s8_q <= rxs;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_nxt;
      t_q     <= t_nxt;
      idx_q   <= idx_nxt;
      shift_q <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    t_nxt     = t_q;
    idx_nxt   = idx_q;
    shift_nxt = shift_q;
    load_byte = 1'b0;
    ferr_set  = 1'b0;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          // The detecting tick is t=0 of the start bit, so the next tick is t=1.
          if (!rxs) begin
            state_nxt = S_START;
            t_nxt     = 4'd1;
          end
        end

        S_START: begin
          t_nxt = t_q + 4'd1;
          if ((t_q == 4'd9) && maj) begin
            state_nxt = S_IDLE;
            t_nxt     = 4'd0;
          end else if (t_q == 4'd15) begin
            state_nxt = S_DATA;
            idx_nxt   = 3'd0;
          end
        end

        S_DATA: begin
          t_nxt = t_q + 4'd1;
          if (t_q == 4'd9) begin
            shift_nxt[idx_q] = maj;
          end
          if (t_q == 4'd15) begin
            if (idx_q == 3'd7) begin
              state_nxt = S_STOP;
            end else begin
              idx_nxt = idx_q + 3'd1;
            end
          end
        end

        S_STOP: begin
          t_nxt = t_q + 4'd1;
          // Leave at mid stop bit so a start edge right after it is not missed.
          if (t_q == 4'd9) begin
            t_nxt = 4'd0;
            if (maj) begin
              load_byte = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              ferr_set  = 1'b1;
              state_nxt = S_BREAK;
            end
          end
        end

        S_BREAK: begin
          if (rxs) begin
            state_nxt = S_IDLE;
          end
        end

        default: begin
          state_nxt = S_IDLE;
          t_nxt     = 4'd0;
        end
      endcase
    end
  end

  // Consumer-facing registers. A load that coincides with ack is a normal
  // hand-over, not an overrun.
  logic [7:0] data_q;
  logic       valid_q;
  logic       overrun_q;
  logic       ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= ferr_set;
      if (load_byte) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        if (valid_q) begin
          overrun_q <= ~bus.ack;
        end
      end else if (bus.ack && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Directed plus randomised bench for uart_receiver. A small clock/baud pair
//   (DIV=5, 80 clk per bit) keeps frames short. Expected outputs come from a
//   byte-level model of the handshake: a good frame delivers its byte, a
//   pending byte that is overwritten without ack sets overrun, ack clears
//   valid and overrun, a low stop bit adds one frame_err pulse.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 12_500;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT      = DIV * 16;
  localparam int BIT_LO   = (BIT * 97 + 99) / 100;
  localparam int BIT_HI   = (BIT * 103) / 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_receiver_if bus ();

  uart_receiver #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; used to place an ack on a load edge.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // frame_err pulse counter and width check.
  int   ferr_cnt  = 0;
  int   ferr_wide = 0;
  logic ferr_prev = 1'b0;
  always @(negedge clk) begin
    ferr_cnt  <= ferr_cnt + ((bus.frame_err === 1'b1) ? 1 : 0);
    ferr_wide <= ferr_wide + (((bus.frame_err === 1'b1) && ferr_prev) ? 1 : 0);
    ferr_prev <= (bus.frame_err === 1'b1);
  end

  int tests = 0;
  int fails = 0;

  logic [7:0] m_data  = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  int         m_ferr  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " data"},      32'(bus.data),    32'(m_data));
    chk({tag, " valid"},     32'(bus.valid),   32'(m_valid));
    chk({tag, " overrun"},   32'(bus.overrun), 32'(m_ovr));
    chk({tag, " busy"},      32'(bus.busy),    32'(0));
    chk({tag, " ferr_cnt"},  32'(ferr_cnt),    32'(m_ferr));
    chk({tag, " ferr_wide"}, 32'(ferr_wide),   32'(0));
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic model_load(input logic [7:0] b, input bit ack_same);
    if (m_valid && !ack_same) m_ovr = 1'b1;
    else if (m_valid && ack_same) m_ovr = 1'b0;
    m_valid = 1'b1;
    m_data  = b;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    @(negedge clk);
    model_ack();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " busy_timeout"}, 32'(bus.busy), 32'(0));
  endtask

  // Sends one frame, one line level per clock from a negedge. abort_bit>=0
  // stops in the middle of that frame bit. ack_k>=0 pulses ack on that clock
  // of the frame; ack_load pulses ack on the edge where the stop bit is voted.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bitp,
                            input int abort_bit, input int ack_k, input bit ack_load);
    logic [9:0] bits;
    int m, d, l, end_k;
    bits  = {stop_ok, b, 1'b0};
    end_k = (abort_bit >= 0) ? (abort_bit * bitp + bitp / 2) : (10 * bitp);
    // First edge seeing the start level at the flop input, plus two
    // synchroniser stages, rounded up to the next tick; the stop bit is
    // voted 16*9+9 ticks later.
    m = cyc + 1;
    d = m + 2;
    while (d % DIV != 0) d++;
    l = d + 153 * DIV;
    for (int k = 0; k < end_k; k++) begin
      bus.rx = bits[k / bitp];
      if (ack_load) begin
        bus.ack = (cyc == l - 1);
      end else if (ack_k >= 0) begin
        bus.ack = (k == ack_k);
        if (k == ack_k) model_ack();
      end
      @(negedge clk);
    end
    bus.ack = 1'b0;
    if (abort_bit < 0) begin
      if (stop_ok) model_load(b, ack_load);
      else         m_ferr++;
    end
  endtask

  initial begin
    #(10 * 90_000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         rbitp;
    bit         rstop;
    int         rmode;

    bus.rx  = 1'b1;
    bus.ack = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    idle(BIT);

    // Single byte, then ack.
    send_frame(8'hA5, 1'b1, BIT, -1, -1, 1'b0);
    idle(4);
    check_state("t1_a5");
    do_ack();
    check_state("t1_ack");

    // Back-to-back, ack during the second frame.
    send_frame(8'h00, 1'b1, BIT, -1, -1, 1'b0);
    check_state("t2_00");
    send_frame(8'hFF, 1'b1, BIT, -1, 2 * BIT, 1'b0);
    idle(4);
    check_state("t2_ff");
    do_ack();

    // Glitch of three ticks: a false start, back to idle at t=9.
    bus.rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    bus.rx = 1'b1;
    chk("t3 busy_rise", 32'(bus.busy), 32'(1));
    wait_idle(9 * DIV, "t3");
    check_state("t3_glitch");

    // Framing error, then a good frame after one idle bit.
    send_frame(8'h3C, 1'b0, BIT, -1, -1, 1'b0);
    idle(BIT);
    wait_idle(4 * DIV, "t4");
    check_state("t4_bad");
    send_frame(8'h3C, 1'b1, BIT, -1, -1, 1'b0);
    idle(4);
    check_state("t4_good");
    do_ack();

    // Overrun, cleared by one ack.
    send_frame(8'h11, 1'b1, BIT, -1, -1, 1'b0);
    send_frame(8'h22, 1'b1, BIT, -1, -1, 1'b0);
    idle(4);
    check_state("t5_ovr");
    do_ack();
    check_state("t5_ack");

    // Ack on the load edge of the second byte: not an overrun.
    send_frame(8'h11, 1'b1, BIT, -1, -1, 1'b0);
    send_frame(8'h22, 1'b1, BIT, -1, -1, 1'b1);
    idle(4);
    check_state("t5_same");
    do_ack();

    // Reset in the middle of a frame with an overrun pending.
    send_frame(8'h77, 1'b1, BIT, -1, -1, 1'b0);
    send_frame(8'h88, 1'b1, BIT, -1, -1, 1'b0);
    check_state("t6_pre");
    send_frame(8'h99, 1'b1, BIT, 5, -1, 1'b0);
    rst = 1'b1;
    #1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    check_state("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    idle(2 * BIT);
    send_frame(8'h5A, 1'b1, BIT, -1, -1, 1'b0);
    idle(4);
    check_state("t6_5a");
    do_ack();

    // Random bytes, baud mismatch inside +/-3%, random stop and ack patterns.
    for (int i = 0; i < 14; i++) begin
      rb    = 8'($urandom);
      rbitp = (i == 0) ? BIT_LO : (i == 1) ? BIT_HI : int'($urandom_range(BIT_LO, BIT_HI));
      rstop = ($urandom_range(0, 4) != 0);
      rmode = int'($urandom_range(0, 2));
      idle(int'($urandom_range(1, BIT)));
      if (rmode == 1) do_ack();
      send_frame(rb, rstop, rbitp, -1, (rmode == 2) ? 3 * rbitp : -1, 1'b0);
      if (!rstop) begin
        idle(BIT);
        wait_idle(4 * DIV, "rnd");
      end
      idle(4);
      check_state("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
